tile_renderer: RTL and testbench

//  Pixel generator directly downstream of vga_sync. Holds a 20x15 tile map (32x32-px tiles)

---
 rtl/tile_renderer.sv | 208 ++++++++++++++++++++
 tb/tb_tile_renderer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_renderer.sv
// tile_renderer
//   Pixel generator sitting directly behind vga_sync. Holds a MAP_W x MAP_H tile map
//   (2^TILE_LG2-pixel square tiles) written by game logic, and turns each pixel position
//   into an RGB colour: tile colour plus a yellow robot marker. The colour path is a
//   three-stage pipeline that advances only on p_tick; HS/VS ride the same pipeline so
//   sync and colour reach the DAC aligned. A one-clock frame_start pulse on the falling
//   edge of vs_in lets game logic update the map during vertical blank.
//
//   After reset a clear sequencer zeroes one map cell per clock (MAP_W*MAP_H clocks).
//   While it runs, map writes are ignored and both read paths return 0.
//
//   Optional build macro: GRID_LINES_EN -- draws a dark grid on tile row/column 0.
//
// Ports
//   CLOCK_50, reset           clock, asynchronous active-high reset
//   p_tick                    pixel enable; the pipeline only moves when high
//   video_on, pixel_x/y       active-area flag and pixel position from vga_sync
//   hs_in, vs_in              raw syncs from vga_sync
//   map_we/addr/wdata         tile write port (addr = row*MAP_W + col)
//   map_rdata                 tile code at map_addr, one clock latency
//   robot_col, robot_row      robot tile position (out of range = no marker)
//   VGA_R/G/B, VGA_HS/VS      pipelined colour and sync
//   frame_start               one-clock pulse after vs_in falls
module tile_renderer #(
  parameter int MAP_W    = 20,
  parameter int MAP_H    = 15,
  parameter int TILE_LG2 = 5
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       map_we,
  input  logic [8:0] map_addr,
  input  logic [2:0] map_wdata,
  output logic [2:0] map_rdata,
  input  logic [4:0] robot_col,
  input  logic [3:0] robot_row,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       frame_start
);

  localparam int         CELLS   = MAP_W * MAP_H;
  localparam logic [8:0] CELLS_L = 9'(CELLS);

  typedef struct packed {
    logic [8:0]          idx;
    logic [TILE_LG2-1:0] ox;
    logic [TILE_LG2-1:0] oy;
    logic                von;
    logic                hs;
    logic                vs;
    logic                hit;
  } s1_t;

  typedef struct packed {
    logic [2:0]          tile;
    logic [TILE_LG2-1:0] ox;
    logic [TILE_LG2-1:0] oy;
    logic                von;
    logic                hs;
    logic                vs;
    logic                hit;
  } s2_t;

  // Sync bits in the pipeline reset to the inactive level so the first few
  // p_ticks after reset cannot emit a spurious sync pulse.
  localparam s1_t S1_RST = '{idx: '0, ox: '0, oy: '0, von: 1'b0, hs: 1'b1, vs: 1'b1, hit: 1'b0};
  localparam s2_t S2_RST = '{tile: '0, ox: '0, oy: '0, von: 1'b0, hs: 1'b1, vs: 1'b1, hit: 1'b0};

  // ---------------- tile map + clear sequencer ----------------
  logic [2:0] mem_q [CELLS];
  logic       clr_busy_q, clr_busy_d;
  logic [8:0] clr_cnt_q, clr_cnt_d;
  logic       mem_we;
  logic [8:0] mem_waddr;
  logic [2:0] mem_wdata;
  logic [2:0] map_rdata_q, map_rdata_d;

  always_comb begin
    clr_busy_d = clr_busy_q;
    clr_cnt_d  = clr_cnt_q;
    if (clr_busy_q) begin
      clr_cnt_d = clr_cnt_q + 9'd1;
      if (clr_cnt_q == CELLS_L - 9'd1) clr_busy_d = 1'b0;
    end
    // The sequencer owns the write port while clearing; out-of-range writes drop.
    mem_we    = clr_busy_q | (map_we & (map_addr < CELLS_L));
    mem_waddr = clr_busy_q ? clr_cnt_q : map_addr;
    mem_wdata = clr_busy_q ? 3'd0 : map_wdata;
    map_rdata_d = 3'd0;
    if (!clr_busy_q && map_addr < CELLS_L) map_rdata_d = mem_q[map_addr];
  end

  always_ff @(posedge CLOCK_50) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // ---------------- render pipeline ----------------
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  logic [23:0] rgb_d;
  logic [7:0]  r_q, g_q, b_q;
  logic        hs_q, vs_q;
  logic [4:0]  col;
  logic [3:0]  row;

  always_comb begin
    col = pixel_x[9:TILE_LG2];
    row = pixel_y[8:TILE_LG2];

    s1_d     = s1_q;
    s1_d.idx = 9'(row) * 9'(MAP_W) + 9'(col);
    s1_d.ox  = pixel_x[TILE_LG2-1:0];
    s1_d.oy  = pixel_y[TILE_LG2-1:0];
    s1_d.von = video_on;
    s1_d.hs  = hs_in;
    s1_d.vs  = vs_in;
    s1_d.hit = (col == robot_col) && (row == robot_row) &&
               (32'(robot_col) < MAP_W) && (32'(robot_row) < MAP_H);

    // Map read happens on the same edge as any write: the pixel sees the old value.
    // Indices past the map (right of / below the screen) read as empty.
    s2_d      = '{tile: 3'd0, ox: s1_q.ox, oy: s1_q.oy, von: s1_q.von,
                  hs: s1_q.hs, vs: s1_q.vs, hit: s1_q.hit};
    if (!clr_busy_q && s1_q.idx < CELLS_L) s2_d.tile = mem_q[s1_q.idx];

    case (s2_q.tile)
      3'd0:    rgb_d = 24'h000000;
      3'd1:    rgb_d = 24'h808080;
      3'd2:    rgb_d = 24'h8B4513;
      3'd3:    rgb_d = 24'h0060FF;
      3'd4:    rgb_d = 24'h00C000;
      default: rgb_d = 24'hFF00FF;
    endcase
`ifdef GRID_LINES_EN
    if (s2_q.ox == '0 || s2_q.oy == '0) rgb_d = 24'h202020;
`endif
    // Robot marker is inset 4 px from each tile edge.
    if (s2_q.hit && s2_q.ox >= 5'd4 && s2_q.ox <= 5'd27 &&
        s2_q.oy >= 5'd4 && s2_q.oy <= 5'd27) rgb_d = 24'hFFFF00;
    if (!s2_q.von) rgb_d = 24'h000000;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clr_busy_q  <= 1'b1;
      clr_cnt_q   <= '0;
      map_rdata_q <= '0;
      s1_q        <= S1_RST;
      s2_q        <= S2_RST;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
    end else begin
      clr_busy_q  <= clr_busy_d;
      clr_cnt_q   <= clr_cnt_d;
      map_rdata_q <= map_rdata_d;
      if (p_tick) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
        r_q  <= rgb_d[23:16];
        g_q  <= rgb_d[15:8];
        b_q  <= rgb_d[7:0];
        hs_q <= s2_q.hs;
        vs_q <= s2_q.vs;
      end
    end
  end

  // ---------------- frame start ----------------
  logic vs_prev_q, vs_prev_d;
  logic fs_q, fs_d;

  always_comb begin
    vs_prev_d = vs_in;
    fs_d      = vs_prev_q & ~vs_in;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vs_prev_q <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      vs_prev_q <= vs_prev_d;
      fs_q      <= fs_d;
    end
  end

  assign map_rdata   = map_rdata_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_tile_renderer.sv
// Scoreboard bench for tile_renderer: stimulus pushes expected pixel colours / map reads
// into queues; monitors pop and compare when the DUT output for that item is due.
module tb_tile_renderer;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       p_tick = 1'b0, video_on = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic       hs_in = 1'b1, vs_in = 1'b1;
  logic       map_we = 1'b0;
  logic [8:0] map_addr = '0;
  logic [2:0] map_wdata = '0;
  logic [2:0] map_rdata;
  logic [4:0] robot_col = 5'd31;
  logic [3:0] robot_row = 4'd15;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, frame_start;

  tile_renderer dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .hs_in(hs_in), .vs_in(vs_in),
    .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata), .map_rdata(map_rdata),
    .robot_col(robot_col), .robot_row(robot_row),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .frame_start(frame_start)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

`ifdef GRID_LINES_EN
  localparam logic GRID = 1'b1;
`else
  localparam logic GRID = 1'b0;
`endif

  int checks = 0, errors = 0;
  logic [25:0] px_q[$];
  string       px_nm[$];
  logic [2:0]  rd_q[$];
  string       rd_nm[$];
  logic        px_tag = 1'b0, rd_tag = 1'b0;
  int          fs_pulses = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  logic [2:0] tag_pipe = '0;
  always @(posedge CLOCK_50) begin : px_mon
    if (reset) tag_pipe = '0;
    else if (p_tick) begin
      tag_pipe = {tag_pipe[1:0], px_tag};
      if (tag_pipe[2]) begin
        #1;
        if (px_q.size() == 0) begin
          errors++;
          $display("FAIL px_unexpected: got %h want none", {VGA_R, VGA_G, VGA_B});
        end else chk(px_nm.pop_front(), {6'd0, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS},
                     {6'd0, px_q.pop_front()});
      end
    end
  end

  always @(posedge CLOCK_50) begin : rd_mon
    if (!reset && rd_tag) begin
      #1;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %h want none", map_rdata);
      end else chk(rd_nm.pop_front(), {29'd0, map_rdata}, {29'd0, rd_q.pop_front()});
    end
  end

  // frame_start: pulse in the clock after vs_in is seen low having been high.
  logic fs_prev = 1'b1;
  always @(posedge CLOCK_50) begin : fs_mon
    logic e;
    if (reset) fs_prev = 1'b1;
    else begin
      e = fs_prev & ~vs_in;
      fs_prev = vs_in;
      #1;
      chk("frame_start", {31'd0, frame_start}, {31'd0, e});
      if (frame_start) fs_pulses++;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic drive_px(input int x, input int y, input logic von, input logic hs,
                          input logic vs, input logic tag, input logic [23:0] rgb,
                          input string nm);
    @(negedge CLOCK_50);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = von; hs_in = hs; vs_in = vs;
    p_tick = 1'b1; px_tag = tag;
    if (tag) begin
      px_q.push_back({rgb, hs, vs});
      px_nm.push_back(nm);
    end
    @(negedge CLOCK_50);
    // Garbage on the off clock: a design that ignores p_tick would pick this up.
    p_tick = 1'b0; px_tag = 1'b0;
    pixel_x = 10'h3FF; pixel_y = 10'h000; video_on = ~von; hs_in = ~hs;
  endtask

  task automatic px(input int x, input int y, input logic [23:0] rgb, input string nm);
    drive_px(x, y, 1'b1, 1'b1, 1'b1, 1'b1, rgb, nm);
  endtask

  task automatic fill();
    drive_px(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0, "");
  endtask

  task automatic wr(input int a, input int d);
    @(negedge CLOCK_50);
    map_we = 1'b1; map_addr = 9'(a); map_wdata = 3'(d);
    @(negedge CLOCK_50);
    map_we = 1'b0;
  endtask

  task automatic rd(input int a, input logic [2:0] exp, input string nm);
    @(negedge CLOCK_50);
    map_addr = 9'(a); rd_tag = 1'b1;
    rd_q.push_back(exp); rd_nm.push_back(nm);
    @(negedge CLOCK_50);
    rd_tag = 1'b0;
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin : watchdog
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout want finish");
    summary();
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin : stim
    repeat (3) @(negedge CLOCK_50);
    chk("rst_R", {24'd0, VGA_R}, 32'd0);
    chk("rst_G", {24'd0, VGA_G}, 32'd0);
    chk("rst_B", {24'd0, VGA_B}, 32'd0);
    chk("rst_HS", {31'd0, VGA_HS}, 32'd1);
    chk("rst_VS", {31'd0, VGA_VS}, 32'd1);
    chk("rst_rdata", {29'd0, map_rdata}, 32'd0);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    reset = 1'b0;

    // Reset mid-clear restarts the sequencer: a write 350 clocks after the first
    // release but only ~200 after the second must still be ignored.
    repeat (150) @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (200) @(negedge CLOCK_50);
    wr(7, 5);
    rd(7, 3'd0, "rd_during_clear");
    repeat (120) @(negedge CLOCK_50);
    rd(7, 3'd0, "clr_restart_drop");
    rd(0, 3'd0, "clr_0");
    rd(150, 3'd0, "clr_150");
    rd(299, 3'd0, "clr_299");

    // Blank map renders black everywhere.
    px(0, 0, 24'h0, "blank_0_0");
    px(320, 240, 24'h0, "blank_320_240");
    px(639, 479, 24'h0, "blank_639_479");

    // Wall at tile 21 (col 1,row 1).
    wr(21, 1);
    px(40, 40, 24'h808080, "wall_40_40");
    px(63, 63, 24'h808080, "wall_63_63");
    px(32, 32, GRID ? 24'h202020 : 24'h808080, "wall_32_32");
    drive_px(40, 40, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0, "video_off");

    // Remaining colour codes on row 0.
    wr(0, 2); wr(1, 4); wr(2, 7);
    px(10, 10, 24'h8B4513, "dirty_pipe");
    px(42, 10, 24'h00C000, "exit");
    px(74, 10, 24'hFF00FF, "reserved");

    // Robot overlay on tile 22 (clean pipe).
    @(negedge CLOCK_50);
    robot_col = 5'd2; robot_row = 4'd1;
    wr(22, 3);
    px(68, 36, 24'hFFFF00, "robot_68_36");
    px(65, 33, 24'h0060FF, "robot_edge_65_33");
    px(91, 59, 24'hFFFF00, "robot_91_59");
    px(92, 60, 24'h0060FF, "robot_edge_92_60");
    px(64, 40, GRID ? 24'h202020 : 24'h0060FF, "grid_64_40");

    // Robot outside the map draws nothing even where the raw compare would hit.
    @(negedge CLOCK_50);
    robot_col = 5'd22; robot_row = 4'd1;
    px(708, 36, 24'h0, "robot_col_oob");
    @(negedge CLOCK_50);
    robot_col = 5'd2; robot_row = 4'd15;
    px(68, 484, 24'h0, "robot_row_oob");
    @(negedge CLOCK_50);
    robot_col = 5'd2; robot_row = 4'd1;

    // Out-of-range write is dropped.
    wr(300, 4);
    rd(300, 3'd0, "rd_300");
    rd(44, 3'd0, "rd_44_no_alias");
    rd(21, 3'd1, "rd_21");
    rd(0, 3'd2, "rd_0");

    // Sync delay and frame_start.
    drive_px(40, 40, 1'b1, 1'b0, 1'b1, 1'b1, 24'h808080, "hs_low");
    drive_px(40, 40, 1'b1, 1'b1, 1'b0, 1'b1, 24'h808080, "vs_low");
    drive_px(40, 40, 1'b1, 1'b1, 1'b1, 1'b1, 24'h808080, "vs_high");

    // Render read and write of tile 21 on the same edge: pixel sees old value.
    px(40, 40, 24'h808080, "same_clk_old");
    @(negedge CLOCK_50);
    p_tick = 1'b1; video_on = 1'b0; pixel_x = '0; pixel_y = '0; hs_in = 1'b1;
    map_we = 1'b1; map_addr = 9'd21; map_wdata = 3'd4;
    @(negedge CLOCK_50);
    p_tick = 1'b0; map_we = 1'b0;
    px(40, 40, 24'h00C000, "same_clk_new");

    repeat (4) fill();
    repeat (3) @(negedge CLOCK_50);
    chk("px_queue_drained", px_q.size(), 32'd0);
    chk("rd_queue_drained", rd_q.size(), 32'd0);
    chk("fs_pulse_count", fs_pulses, 32'd1);

    // Reset clears previously written cells.
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (305) @(negedge CLOCK_50);
    rd(21, 3'd0, "reclear_21");
    rd(0, 3'd0, "reclear_0");
    repeat (2) @(negedge CLOCK_50);

    summary();
    $finish;
  end

endmodule
